// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive path.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // STATUS register layout
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;
  localparam int STAT_FERR_BIT  = 2;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_W     = 5;

  // DATA read result when the FIFO holds nothing
  localparam logic [31:0] EMPTY_READ = 32'h8000_0000;

  // Clocks per serial bit, rounded to nearest
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop in the same cycle; head is shown combinationally.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A pop on empty is ignored; a push on full only lands if a pop frees the slot
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointer and occupancy; pointers wrap naturally at the depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// 8N1 serial receiver feeding a byte FIFO, read through a two-register bus port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronized line
// START | half-bit wait, then confirm start bit is still low
// DATA  | sample 8 data bits at bit centres, LSB first
// STOP  | sample stop bit; high pushes the byte, low flags framing
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  input  logic        address,
  input  logic        readenable,
  output logic [31:0] readdata,
  output logic        rx_valid
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic              sync1_q, sync2_q, line_prev_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_q, push_d;
  logic              ferr_set;
  logic              cnt_zero, line_fall;

  logic              overrun_q, overrun_d;
  logic              framing_err_q, framing_err_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       status_word;
  logic              data_rd, status_rd, overrun_set;

  logic [7:0]            fifo_head;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [DEPTH_LOG2:0]   fifo_count;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q     <= serial_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  // Needing a seen-high sample before the edge keeps a stuck-low line
  // (e.g. after a framing error) from re-triggering the receiver.
  assign line_fall = line_prev_q & ~sync2_q;
  assign cnt_zero  = (cnt_q == '0);

  // Receiver next-state: bit timing runs on a down-counter reloaded per bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_fall) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!sync2_q) begin
            state_d   = DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          state_d = IDLE;
          if (sync2_q) push_d   = 1'b1;
          else         ferr_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers; push is registered so the FIFO sees a clean pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
    end
  end

  assign data_rd   = readenable & ~address;
  assign status_rd = readenable &  address;
  assign fifo_pop  = data_rd & ~fifo_empty;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid    = (fifo_count != '0);
  assign overrun_set = push_q & fifo_full & ~fifo_pop;

  // Status word and sticky flags; a new set in the clearing cycle wins
  always_comb begin
    status_word                                 = '0;
    status_word[STAT_VALID_BIT]                 = rx_valid;
    status_word[STAT_OVR_BIT]                   = overrun_q;
    status_word[STAT_FERR_BIT]                  = framing_err_q;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);

    overrun_d     = overrun_set | (overrun_q & ~status_rd);
    framing_err_d = ferr_set | (framing_err_q & ~status_rd);

    readdata_d = readdata_q;
    if (data_rd) readdata_d = fifo_empty ? EMPTY_READ : {24'd0, fifo_head};
    else if (status_rd) readdata_d = status_word;
  end

  // Bus-side registers
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
      readdata_q    <= '0;
    end else begin
      overrun_q     <= overrun_d;
      framing_err_q <= framing_err_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Scenario bench for serial_rx_fifo at DIV = 8, FIFO depth 4.
module tb_serial_rx_fifo;

  localparam int BIT_CYC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b1;
  logic        address = 1'b0;
  logic        readenable = 1'b0;
  logic [31:0] readdata;
  logic        rx_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  serial_rx_fifo #(
    .CLK_HZ     (800),
    .BAUD       (100),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .address    (address),
    .readenable (readenable),
    .readdata   (readdata),
    .rx_valid   (rx_valid)
  );

  always #5 clk = ~clk;

  // Expected next DATA read value, consuming the scoreboard head
  function automatic logic [31:0] next_data();
    if (exp_q.size() == 0) return 32'h8000_0000;
    return {24'd0, exp_q.pop_front()};
  endfunction

  // Drive one 8N1 frame then 4 idle cycles; all drives at posedge+1
  task automatic send_byte(input logic [7:0] b, input logic stop_hi, input bit track);
    serial_in = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
    serial_in = stop_hi;
    repeat (BIT_CYC) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (track && stop_hi && exp_q.size() < 4) exp_q.push_back(b);
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    readenable = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    readenable = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata got %h want %h", readdata, 32'h0);
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid);
    end
  endtask

  task automatic test_empty_read();
    logic [31:0] d;
    bus_read(1'b0, d);
    n_checks++;
    if (d !== 32'h8000_0000) begin
      n_fail++; $display("FAIL empty_data got %h want %h", d, 32'h8000_0000);
    end
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL empty_status got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_two_bytes();
    logic [31:0] d, e;
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'hA3, 1'b1, 1'b1);
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0000_0021) begin
      n_fail++; $display("FAIL two_status got %h want %h", d, 32'h21);
    end
    for (int i = 0; i < 2; i++) begin
      e = next_data();
      bus_read(1'b0, d);
      n_checks++;
      if (d !== e) begin
        n_fail++; $display("FAIL two_data%0d got %h want %h", i, d, e);
      end
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL two_rx_valid got %b want 0", rx_valid);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d, e;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b1);
    n_checks++;
    if (rx_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_rx_valid got %b want 1", rx_valid);
    end
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0000_0043) begin
      n_fail++; $display("FAIL ovr_status1 got %h want %h", d, 32'h43);
    end
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0000_0041) begin
      n_fail++; $display("FAIL ovr_status2 got %h want %h", d, 32'h41);
    end
    for (int i = 0; i < 4; i++) begin
      e = next_data();
      bus_read(1'b0, d);
      n_checks++;
      if (d !== e) begin
        n_fail++; $display("FAIL ovr_data%0d got %h want %h", i, d, e);
      end
    end
  endtask

  task automatic test_framing();
    logic [31:0] d;
    send_byte(8'h7E, 1'b0, 1'b1);
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      n_fail++; $display("FAIL ferr_status1 got %h want %h", d, 32'h4);
    end
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL ferr_status2 got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (dut.state_q !== serial_pkg::IDLE) begin
      n_fail++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, serial_pkg::IDLE);
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_rx_valid got %b want 0", rx_valid);
    end
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL glitch_status got %h want %h", d, 32'h0);
    end
    send_byte(8'h3C, 1'b1, 1'b1);
    e = next_data();
    bus_read(1'b0, d);
    n_checks++;
    if (d !== e) begin
      n_fail++; $display("FAIL glitch_rearm got %h want %h", d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1);
    readenable = 1'b1;
    address    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = next_data();
      @(posedge clk);
      #1;
      n_checks++;
      if (readdata !== e) begin
        n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, readdata, e);
      end
    end
    address = 1'b1;
    @(posedge clk);
    #1;
    readenable = 1'b0;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_status got %h want %h", readdata, 32'h0);
    end
    address = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_hold got %h want %h", readdata, 32'h0);
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d, e;
    bit seen;
    for (int i = 1; i <= 4; i++) send_byte(8'hA0 + 8'(i), 1'b1, 1'b1);
    e = next_data();
    seen = 1'b0;
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 300 && !seen; i++) begin
          @(posedge clk);
          #1;
          if (dut.push_q === 1'b1) seen = 1'b1;
        end
        if (seen) begin
          bus_read(1'b0, d);
          n_checks++;
          if (d !== e) begin
            n_fail++; $display("FAIL full_rw_data got %h want %h", d, e);
          end
        end else begin
          n_checks++;
          n_fail++; $display("FAIL full_rw_timeout got no push want push within 300 cycles");
        end
      end
    join
    exp_q.push_back(8'hA5);
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0000_0041) begin
      n_fail++; $display("FAIL full_rw_status got %h want %h", d, 32'h41);
    end
    for (int i = 0; i < 4; i++) begin
      e = next_data();
      bus_read(1'b0, d);
      n_checks++;
      if (d !== e) begin
        n_fail++; $display("FAIL full_rw_data%0d got %h want %h", i, d, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    send_byte(8'h5A, 1'b1, 1'b1);
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0000_0011) begin
      n_fail++; $display("FAIL mid_pre_status got %h want %h", d, 32'h11);
    end
    serial_in = 1'b0;
    repeat (3 * BIT_CYC) @(posedge clk);
    #1;
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_readdata got %h want %h", readdata, 32'h0);
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rx_valid got %b want 0", rx_valid);
    end
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_late_rx_valid got %b want 0", rx_valid);
    end
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_status got %h want %h", d, 32'h0);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_empty_read();
    test_two_bytes();
    test_overrun();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
